// File: rtl/pin_entry_collector_pkg.sv
// ============================================================================
// pin_entry_collector_pkg : shared state encoding and width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package pin_entry_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PRESENT = 2'd2
    } state_e;

    // digitCount must be able to show 0..NUM_DIGITS inclusive
    function automatic int count_width(input int num_digits);
        return (num_digits < 1) ? 1 : $clog2(num_digits + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pin_entry_collector_onehot_encoder.sv
// ============================================================================
// onehot_encoder : button vector -> digit index, valid only when exactly one hot
// Rev 1.0
// ============================================================================
`default_nettype none

module onehot_encoder #(
    parameter int NUM_BUTTONS = 4,
    parameter int DIGIT_WIDTH = 2
) (
    input  logic [NUM_BUTTONS-1:0] buttons_i,
    output logic [DIGIT_WIDTH-1:0] digit_o,
    output logic                   valid_o
);

    // OR of set-bit indices; only meaningful when valid_o is high
    always_comb begin
        digit_o = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (buttons_i[i]) begin
                digit_o = digit_o | DIGIT_WIDTH'(i);
            end
        end
    end

    assign valid_o = (buttons_i != '0) &&
                     ((buttons_i & (buttons_i - NUM_BUTTONS'(1))) == '0);

endmodule

`default_nettype wire

// File: rtl/pin_entry_collector.sv
// ============================================================================
// pin_entry_collector : assembles NUM_DIGITS button presses into a PIN code
// Optional macro ENTRY_TIMEOUT_EN adds an inactivity abort. Rev 1.0
// ============================================================================
`default_nettype none

module pin_entry_collector
    import pin_entry_collector_pkg::*;
#(
    parameter int NUM_BUTTONS    = 4,
    parameter int DIGIT_WIDTH    = 2,
    parameter int NUM_DIGITS     = 4,
    parameter int CODE_LENGTH    = NUM_DIGITS * DIGIT_WIDTH,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_BUTTONS-1:0]              buttonPressed,
    output logic                                key,
    output logic [CODE_LENGTH-1:0]              code,
    output logic [count_width(NUM_DIGITS)-1:0]  digitCount,
    output logic                                entryError
);

    localparam int CNT_W = count_width(NUM_DIGITS);

    if ((1 << DIGIT_WIDTH) < NUM_BUTTONS) begin : g_bad_digit_width
        $error("DIGIT_WIDTH too small for NUM_BUTTONS");
    end
    if (CODE_LENGTH != NUM_DIGITS * DIGIT_WIDTH) begin : g_bad_code_length
        $error("CODE_LENGTH must equal NUM_DIGITS*DIGIT_WIDTH");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be positive");
    end

    logic [DIGIT_WIDTH-1:0] w_digit;
    logic                   w_valid;
    logic                   w_invalid;

    onehot_encoder #(
        .NUM_BUTTONS (NUM_BUTTONS),
        .DIGIT_WIDTH (DIGIT_WIDTH)
    ) u_encoder (
        .buttons_i (buttonPressed),
        .digit_o   (w_digit),
        .valid_o   (w_valid)
    );

    assign w_invalid = (|buttonPressed) && !w_valid;

    state_e                 state_q, state_d;
    logic [CODE_LENGTH-1:0] shift_q, shift_d;
    logic [CODE_LENGTH-1:0] code_q,  code_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   key_q,   key_d;
    logic                   err_q,   err_d;

    // Outside COLLECT a new entry starts from an empty shift register
    logic [CODE_LENGTH-1:0] w_base_shift;
    logic [CNT_W-1:0]       w_base_count;
    assign w_base_shift = (state_q == ST_COLLECT) ? shift_q : '0;
    assign w_base_count = (state_q == ST_COLLECT) ? count_q : '0;

`ifdef ENTRY_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        code_d  = code_q;
        key_d   = 1'b0;
        err_d   = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
        tmo_d   = '0;
`endif
        if (state_q != ST_COLLECT) begin
            state_d = ST_IDLE;
            count_d = '0;
        end

        if (w_valid) begin
            shift_d = (w_base_shift << DIGIT_WIDTH) | CODE_LENGTH'(w_digit);
            count_d = w_base_count + CNT_W'(1);
            if (count_d == CNT_W'(NUM_DIGITS)) begin
                state_d = ST_PRESENT;
                code_d  = shift_d;
                key_d   = 1'b1;
            end else begin
                state_d = ST_COLLECT;
            end
        end else begin
            err_d = w_invalid;
`ifdef ENTRY_TIMEOUT_EN
            if (state_q == ST_COLLECT) begin
                if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    shift_d = '0;
                    count_d = '0;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            code_q  <= '0;
            count_q <= '0;
            key_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            code_q  <= code_d;
            count_q <= count_d;
            key_q   <= key_d;
            err_q   <= err_d;
        end
    end

`ifdef ENTRY_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign key        = key_q;
    assign code       = code_q;
    assign digitCount = count_q;
    assign entryError = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pin_entry_collector.sv
// ============================================================================
// tb_pin_entry_collector : vector table, directed corner cases and random
// stimulus against a digit-queue reference model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_pin_entry_collector;

    localparam int NB  = 4;
    localparam int DW  = 2;
    localparam int ND  = 4;
    localparam int TMO = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] buttonPressed = '0;
    logic       key;
    logic [7:0] code;
    logic [2:0] digitCount;
    logic       entryError;

    pin_entry_collector #(
        .NUM_BUTTONS    (NB),
        .DIGIT_WIDTH    (DW),
        .NUM_DIGITS     (ND),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .buttonPressed (buttonPressed),
        .key           (key),
        .code          (code),
        .digitCount    (digitCount),
        .entryError    (entryError)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // reference model: pending digits held in a queue
    int         q[$];
    int         idle = 0;
    logic       exp_key = 1'b0;
    logic [7:0] exp_code = '0;
    logic [2:0] exp_cnt = '0;
    logic       exp_err = 1'b0;
    logic       prev_key = 1'b0;

    typedef struct {
        logic [3:0] btn;
        logic       k;
        logic [7:0] c;
        logic [2:0] n;
        logic       e;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        idle     = 0;
        exp_key  = 1'b0;
        exp_code = '0;
        exp_cnt  = '0;
        exp_err  = 1'b0;
        prev_key = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] b);
        int n;
        n = $countones(b);
        exp_key = 1'b0;
        exp_err = 1'b0;
        if (n == 1) begin
            idle = 0;
            for (int i = 0; i < NB; i++) if (b[i]) q.push_back(i);
            if (q.size() == ND) begin
                exp_code = '0;
                foreach (q[k]) exp_code = (exp_code << DW) | 8'(q[k]);
                exp_key = 1'b1;
                exp_cnt = 3'(ND);
                q.delete();
            end else begin
                exp_cnt = 3'(q.size());
            end
        end else begin
            exp_err = (n > 1);
            exp_cnt = 3'(q.size());
`ifdef ENTRY_TIMEOUT_EN
            if (q.size() > 0) begin
                idle++;
                if (idle == TMO) begin
                    q.delete();
                    idle    = 0;
                    exp_err = 1'b1;
                    exp_cnt = '0;
                end
            end
`endif
        end
    endtask

    task automatic step(input logic [3:0] b);
        buttonPressed = b;
        @(posedge clock);
        model_edge(b);
        #1;
        chk("key", key, exp_key);
        chk("code", code, exp_code);
        chk("digitCount", digitCount, exp_cnt);
        chk("entryError", entryError, exp_err);
        chk("key_adjacent", key & prev_key, 0);
        prev_key = key;
    endtask

    initial begin
        tbl[0]  = '{4'b1000, 1'b0, 8'h00, 3'd1, 1'b0};
        tbl[1]  = '{4'b0010, 1'b0, 8'h00, 3'd2, 1'b0};
        tbl[2]  = '{4'b0001, 1'b0, 8'h00, 3'd3, 1'b0};
        tbl[3]  = '{4'b0100, 1'b1, 8'hD2, 3'd4, 1'b0};
        tbl[4]  = '{4'b0000, 1'b0, 8'hD2, 3'd0, 1'b0};
        tbl[5]  = '{4'b0001, 1'b0, 8'hD2, 3'd1, 1'b0};
        tbl[6]  = '{4'b0010, 1'b0, 8'hD2, 3'd2, 1'b0};
        tbl[7]  = '{4'b0101, 1'b0, 8'hD2, 3'd2, 1'b1};
        tbl[8]  = '{4'b0001, 1'b0, 8'hD2, 3'd3, 1'b0};
        tbl[9]  = '{4'b1000, 1'b1, 8'h13, 3'd4, 1'b0};
        tbl[10] = '{4'b0000, 1'b0, 8'h13, 3'd0, 1'b0};
        tbl[11] = '{4'b0000, 1'b0, 8'h13, 3'd0, 1'b0};

        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_key", key, 0);
        chk("reset_code", code, 0);
        chk("reset_count", digitCount, 0);
        chk("reset_err", entryError, 0);
        reset = 1'b1;

        // vector table: entry 3,1,0,2 then entry with a multi-hot press inside
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].btn);
            chk("tbl_key", key, tbl[i].k);
            chk("tbl_code", code, tbl[i].c);
            chk("tbl_count", digitCount, tbl[i].n);
            chk("tbl_err", entryError, tbl[i].e);
        end

        // asynchronous reset after three digits
        step(4'b1000);
        step(4'b1000);
        step(4'b1000);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("async_rst_key", key, 0);
        chk("async_rst_code", code, 0);
        chk("async_rst_count", digitCount, 0);
        chk("async_rst_err", entryError, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) step(4'b0010);
        chk("post_rst_code", code, 8'h55);
        chk("post_rst_key", key, 1);

        // press landing in the key cycle starts the next entry
        step(4'b0000);
        step(4'b0010);
        step(4'b0100);
        step(4'b1000);
        step(4'b0001);
        chk("present_key", key, 1);
        chk("present_code", code, 8'h6C);
        step(4'b0100);
        chk("present_next_count", digitCount, 1);
        chk("present_next_key", key, 0);
        step(4'b0001);
        step(4'b0010);
        step(4'b1000);
        chk("carry_code", code, 8'h87);
        chk("carry_key", key, 1);

`ifdef ENTRY_TIMEOUT_EN
        step(4'b0000);
        step(4'b0010);
        step(4'b0010);
        for (int i = 0; i < TMO - 1; i++) begin
            step(4'b0000);
            chk("tmo_wait_err", entryError, 0);
        end
        step(4'b0000);
        chk("tmo_err", entryError, 1);
        chk("tmo_count", digitCount, 0);
        chk("tmo_key", key, 0);
        step(4'b0001);
        step(4'b0001);
        for (int i = 0; i < TMO - 1; i++) step(4'b0000);
        step(4'b0100);
        chk("tmo_race_err", entryError, 0);
        chk("tmo_race_count", digitCount, 3);
        step(4'b1000);
        chk("tmo_race_code", code, 8'h0B);
`endif

        // back-to-back entries, one press every cycle
        for (int i = 0; i < 4 * ND; i++) step(4'b0001 << $urandom_range(0, NB - 1));
        step(4'b0000);

        // random mix of idle, one-hot and arbitrary vectors
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [3:0] b;
            r = int'($urandom_range(0, 99));
            if (r < 45)      b = 4'b0000;
            else if (r < 85) b = 4'b0001 << $urandom_range(0, NB - 1);
            else             b = 4'($urandom);
            step(b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pin_entry_collector.md
Name: pin_entry_collector

Overview:
Upstream stage of the PIN tester. Consumes one-cycle button-press pulses from the button edge detectors and encodes each press as a digit. It accumulates NUM_DIGITS digits, then presents the assembled code with a one-cycle key strobe to the PIN tester (its key/code inputs). Optionally, an inactivity timeout aborts a partial entry.

Parameters:
NUM_BUTTONS, 4, number of digit buttons; button i encodes digit value i
DIGIT_WIDTH, 2, bits per digit; must satisfy 2**DIGIT_WIDTH >= NUM_BUTTONS
NUM_DIGITS, 4, digits per PIN entry
CODE_LENGTH, NUM_DIGITS*DIGIT_WIDTH, width of the presented code; must match the PIN tester's CODE_LENGTH
TIMEOUT_CYCLES, 50000000, idle cycles before a partial entry is discarded (used only with ENTRY_TIMEOUT_EN)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
buttonPressed  input  NUM_BUTTONS  one-cycle rising-edge pulses, one bit per button
key  output  1  one-cycle strobe: code holds a complete entry
code  output  CODE_LENGTH  last completed entry, first digit in MSBs
digitCount  output  clog2(NUM_DIGITS+1)  digits captured in the current entry
entryError  output  1  one-cycle pulse: multi-hot press or timeout discarded input

Behaviour:
- Reset (reset low, async): state=IDLE; key=0, code=0, digitCount=0, entryError=0; shift register and timeout counter cleared.
- Valid press: exactly one bit of buttonPressed set (one-hot). Digit = index of the set bit, zero-extended to DIGIT_WIDTH.
- Invalid press: more than one bit set. It is discarded and pulses entryError next cycle; digitCount and shift register are unchanged. All-zero means no event.
- States:
  - IDLE: valid press -> shift digit in, digitCount=1, go COLLECT. If NUM_DIGITS==1, go PRESENT directly.
  - COLLECT: valid press -> shiftReg <= {shiftReg[CODE_LENGTH-DIGIT_WIDTH-1:0], digit}, digitCount+1. The press making digitCount==NUM_DIGITS goes to PRESENT.
  - PRESENT (exactly 1 cycle): code <= shiftReg including the final digit; key=1 in the same registered cycle code updates; digitCount <= 0; go IDLE.
- Latency: final valid press in cycle N -> key=1 and new code visible in cycle N+1.
- code is stable between key strobes. It does not change during collection.
- A press arriving in the PRESENT cycle is accepted as digit 1 of the next entry: shiftReg reloads with that digit, digitCount=1, next state COLLECT. No press is lost.
- key never asserts on two consecutive cycles.
- Reset mid-entry: the partial entry is lost, code returns to 0, and no key pulse is issued.
- Outputs are registered; no combinational path from buttonPressed to any output.

Optional Feature:
ENTRY_TIMEOUT_EN
- Defined: in COLLECT, a counter counts cycles with no valid press and is cleared by each valid press. On reaching TIMEOUT_CYCLES-1 it clears shiftReg and digitCount, pulses entryError, and returns to IDLE. A valid press in the same cycle as expiry wins: the press is accepted and the counter is cleared. The counter is held at 0 outside COLLECT.
- Not defined: no counter is built; a partial entry waits indefinitely. entryError pulses only for invalid presses.

Decomposition:
- Shared package: state encodings IDLE/COLLECT/PRESENT, and a width helper for digitCount.
- Sub-module onehot_encoder: NUM_BUTTONS -> DIGIT_WIDTH index plus a valid flag (exactly one bit set). Purely combinational.
- Collector FSM, shift register and optional timeout counter stay in the top module.

Test Plan:
- Defaults; press buttons 3,1,0,2 one cycle apart -> key=1 for exactly one cycle, cycle after final press; code=8'b11_01_00_10; digitCount back to 0.
- Press 0b0101 mid-entry after two digits -> entryError pulses once; digitCount stays 2; next two valid presses complete the entry normally.
- Reset low after 3 digits -> key, code, digitCount and entryError are 0 immediately (async); a subsequent 4 presses produce a fresh code.
- Press arriving in the PRESENT cycle -> key=1 for the first entry; digitCount=1 next cycle; the new digit is the MSB group of the following code.
- ENTRY_TIMEOUT_EN, TIMEOUT_CYCLES=8; 2 digits then idle -> entryError at cycle 8 of idle, digitCount=0, no key; a press on the expiry cycle is accepted with no error.
- Back-to-back full entries, one press per cycle -> key pulses every NUM_DIGITS cycles, never two cycles adjacent, and each code is correct.
